// File: rtl/img_stream_gen.sv
// Raster-order frame source: reads one frame from a 1-cycle-latency pixel memory
// and emits it as a vsync/href/gray stream with programmable porches and row blanking.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no frame in progress, waiting for i_start
// S_VFRONT | vertical front porch (read-side view, two cycles shorter)
// S_ACTIVE | issuing pixel reads for one row
// S_HBLANK | no reads between two rows
// S_VBACK  | vertical back porch (read-side view, two cycles longer)
//
// The FSM tracks the read side, which leads href by two cycles (one cycle of
// memory latency plus one output register). Shortening the front porch and
// stretching the back porch by two keeps vsync aligned with the visible frame.
module img_stream_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 20,
  parameter int V_FRONT   = 10,
  parameter int V_BACK    = 10,
  parameter int ADDR_W    = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_per_img_vsync,
  output logic              o_per_img_href,
  output logic [7:0]        o_per_img_gray
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VFRONT = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_VBACK  = 3'd4
  } state_t;

  localparam bit          HAS_VF   = (V_FRONT > 2);
  localparam logic [11:0] LD_VF    = HAS_VF ? 12'(V_FRONT - 3) : 12'd0;
  localparam logic [11:0] LD_ACT   = 12'(IMG_HDISP - 1);
  localparam logic [11:0] LD_HB    = 12'(H_BLANK - 1);
  localparam logic [11:0] LD_VB    = 12'(V_BACK + 1);
  localparam logic [11:0] LAST_ROW = 12'(IMG_VDISP - 1);

  state_t              r_state;
  state_t              w_nxt;
  logic [11:0]         r_hcnt;
  logic [11:0]         r_vcnt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_en;
  logic                r_href_d1;
  logic                r_href;
  logic                r_vsync;
  logic                r_frame_done;
  logic [7:0]          r_gray;

  logic                w_tc;
  logic                w_frame_start;
  logic                w_row_end;
  logic                w_done;
  logic [11:0]         w_hcnt_nxt;

  assign w_tc = (r_hcnt == 12'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_nxt = HAS_VF ? S_VFRONT : S_ACTIVE;
      S_VFRONT: if (w_tc) w_nxt = S_ACTIVE;
      S_ACTIVE: if (w_tc) w_nxt = (r_vcnt == LAST_ROW) ? S_VBACK : S_HBLANK;
      S_HBLANK: if (w_tc) w_nxt = S_ACTIVE;
      S_VBACK:  if (w_tc) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_frame_start = (r_state == S_IDLE) && i_start;
    w_row_end     = (r_state == S_ACTIVE) && w_tc;
    w_done        = (r_state == S_VBACK) && w_tc;
    w_hcnt_nxt    = w_tc ? 12'd0 : r_hcnt - 12'd1;
    // Every state change reloads the phase timer with that phase's length minus one.
    if (w_nxt != r_state) begin
      case (w_nxt)
        S_VFRONT: w_hcnt_nxt = LD_VF;
        S_ACTIVE: w_hcnt_nxt = LD_ACT;
        S_HBLANK: w_hcnt_nxt = LD_HB;
        S_VBACK:  w_hcnt_nxt = LD_VB;
        default:  w_hcnt_nxt = 12'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_rd_addr <= '0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      if (w_frame_start) begin
        r_vcnt    <= '0;
        r_rd_addr <= '0;
      end else begin
        if (w_row_end) r_vcnt <= r_vcnt + 12'd1;
        if (r_rd_en) r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end
    end
  end

  // Output pipeline: read strobe, memory latency stage, then registered pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_en      <= 1'b0;
      r_href_d1    <= 1'b0;
      r_href       <= 1'b0;
      r_gray       <= '0;
      r_vsync      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en      <= (w_nxt == S_ACTIVE);
      r_href_d1    <= r_rd_en;
      r_href       <= r_href_d1;
      r_gray       <= r_href_d1 ? i_rd_data : 8'd0;
      r_vsync      <= (w_nxt != S_IDLE);
      r_frame_done <= w_done;
    end
  end

  assign o_busy          = r_vsync;
  assign o_frame_done    = r_frame_done;
  assign o_rd_en         = r_rd_en;
  assign o_rd_addr       = r_rd_addr;
  assign o_per_img_vsync = r_vsync;
  assign o_per_img_href  = r_href;
  assign o_per_img_gray  = r_gray;

endmodule

// File: doc/img_stream_gen.md
Name: img_stream_gen

Overview:
- Frame source that produces the per-pixel video stream (vsync/href/8-bit gray) consumed by the matrix generators and filters.
- Reads one frame from a synchronous pixel memory with 1-cycle read latency, in raster order.
- Emits the frame with programmable vertical front/back porch and inter-row blanking.
- Used as the test-pattern or frame-buffer playback front end of the sobel/sharpen pipeline.

Parameters:
- IMG_HDISP, 640: active pixels per row.
- IMG_VDISP, 480: active rows per frame.
- H_BLANK, 20: href-low cycles between consecutive rows. Must be >= 1 and must be >= the downstream DELAY_NUM.
- V_FRONT, 10: cycles with vsync high and href low before the first row. Must be >= 2.
- V_BACK, 10: cycles with vsync high and href low after the last row. Must be >= 1.
- ADDR_W, 19: pixel memory address width. 2^ADDR_W must be >= IMG_HDISP*IMG_VDISP.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only when busy=0.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- rd_en  out  1  pixel memory read strobe.
- rd_addr  out  ADDR_W  pixel address, row*IMG_HDISP+col.
- rd_data  in  8  pixel data, valid the cycle after rd_en.
- per_img_vsync  out  1  frame valid.
- per_img_href  out  1  row/pixel valid.
- per_img_gray  out  8  pixel value.

Behaviour:
- Reset (rst=1 at a clk edge, also mid-frame): FSM→IDLE, all counters 0, all outputs 0 on the next cycle. An in-flight read is discarded.
- FSM states: IDLE, V_FRONT, ACTIVE, H_BLANK, V_BACK.
  - IDLE: start=1 → V_FRONT.
  - V_FRONT: after V_FRONT cycles → ACTIVE.
  - ACTIVE: after IMG_HDISP cycles → H_BLANK if rows remain, otherwise V_BACK.
  - H_BLANK: after H_BLANK cycles → ACTIVE.
  - V_BACK: after V_BACK cycles → IDLE.
- Let start be sampled at cycle t0. per_img_vsync=1 and busy=1 from t0+1.
- vsync stays high for V_FRONT + IMG_VDISP*IMG_HDISP + (IMG_VDISP-1)*H_BLANK + V_BACK cycles, then falls.
- In the first cycle with vsync=0: busy=0 and frame_done=1. A start in that cycle is accepted, so vsync is low for exactly 1 cycle between back-to-back frames.
- href is high for exactly IMG_HDISP consecutive cycles per row. Rows are separated by exactly H_BLANK low cycles. href is never high when vsync is low.
- Read pipeline: rd_en for pixel (r,c) is asserted 2 cycles before that pixel appears on the outputs. rd_data is registered once into per_img_gray.
  - rd_en is high exactly IMG_HDISP*IMG_VDISP cycles per frame.
  - rd_addr increments by 1 per read, starting at 0, with no gaps within a row. It is held when rd_en=0.
- per_img_gray = 0 whenever href=0. It equals mem[r*IMG_HDISP+c] on the c-th href cycle of row r.
- All outputs are registered. No combinational path from any input to any output.
- Counters: hcnt and vcnt are 12 bits, address counter is ADDR_W bits. No wrap within a frame; all are cleared at frame start.
- start while busy=1 is ignored, not queued.
- rst and start high together: rst wins.

Test Plan:
- Setup for all: IMG_HDISP=4, IMG_VDISP=3, H_BLANK=2, V_FRONT=3, V_BACK=2, mem[a]=a+16.
- Single frame, start pulse at t0:
  - vsync high t0+1..t0+21 (21 cycles).
  - href high t0+4..7, t0+10..13, t0+16..19.
  - gray sequence 16..27.
  - frame_done=1 only at t0+22.
- Read interface, same frame: rd_en high at t0+2..5, t0+8..11, t0+14..17; rd_addr 0..11; zero reads outside those cycles.
- start held high continuously: vsync low for exactly one cycle between frames; second frame is identical to the first; frame_done pulses once per frame.
- start pulsed at t0+8 (mid-frame): no effect; frame timing identical to the single-frame case.
- rst asserted at t0+11 for 1 cycle: at t0+12 vsync=href=rd_en=busy=0 and gray=0. A new start then produces a full frame from address 0.
- Gray gating: gray=0 during every H_BLANK, V_FRONT and V_BACK cycle, even though rd_data is driven to 0xFF there.
